pulse_peak_detector: RTL and testbench
======================================

// Module: pulse_peak_detector
// PURPOSE
//  Downstream consumer of the 20-bit FIR-filtered PPG stream. Detects pulse peaks with
//  hysteresis and a refractory window, and measures the beat period in samples. Reports the
//  AC amplitude (peak - trough) and DC trough per beat for the SpO2 ratio / heart-rate stage.
// PARAMETERS
//  DATA_W      20    width of filtered sample
//  CNT_W       16    width of interval/period counters
//  WARMUP      24    valid samples ignored after reset/timeout (FIR fill: 22 taps + 2 regs)
//  HYST        64    absolute hysteresis, LSBs of sample
//  REFRACT     64    valid samples blanked after each beat
//  MAX_PERIOD  4095  interval (samples) with no beat before pulse loss; < 2^CNT_W
// PORTS
//  CLK_Filter  in   1       clock, rising edge; the FIR output clock
//  rst_n       in   1       asynchronous, active-low reset
//  sample_en   in   1       Out_Filtered holds a new sample this cycle; tie 1 if one per clock
//  Out_Filtered in  DATA_W  unsigned filtered sample
//  beat        out  1       one-cycle pulse per detected peak
//  period      out  CNT_W   samples between last two beats
//  ac_amp      out  DATA_W  peak - trough of last beat
//  dc_level    out  DATA_W  trough of last beat
//  hr_valid    out  1       period is valid (>=2 beats since last loss)
//  pulse_lost  out  1       one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: all outputs 0; state WARMUP; counters, thr, win_min, win_max, peak_val = 0.
//  - All state/counters advance only when sample_en=1; otherwise everything holds.
//  - Outputs are registered: beat/pulse_lost and updated values appear the cycle after the
//    deciding sample x; never more than one of beat/pulse_lost per cycle.
//  - interval counts valid samples, saturates at MAX_PERIOD; cleared on beat and timeout.
//  - FSM:
//    WARMUP: count WARMUP samples; on last, win_min=win_max=thr=x, interval=0 -> SEARCH.
//    SEARCH: win_min=min(win_min,x); if x > thr+HYST: peak_val=x -> RISE.
//    RISE:   if x > peak_val: peak_val=x. If x+HYST < peak_val: beat=1,
//            ac_amp=peak_val-win_min, dc_level=win_min, thr=win_min+((peak_val-win_min)>>1),
//            win_min=x, interval=0 -> REFRACT.
//    REFRACT: win_min=min(win_min,x); after REFRACT samples -> SEARCH.
//  - Period: first beat after reset/timeout sets an internal have_beat flag only, period held;
//    later beats load period=interval+1 and set hr_valid=1.
//  - Timeout: interval reaches MAX_PERIOD in SEARCH/RISE -> pulse_lost=1, hr_valid=0,
//    have_beat=0, period=0, count restarts -> WARMUP. Beat condition in same sample wins.
//  - Arithmetic: compare sums in DATA_W+1 bits (thr+HYST, x+HYST never wrap); differences
//    are non-negative by construction (win_min <= peak_val).
//  - Reset asserted mid-operation: immediate return to reset values, no partial beat output.
// STRUCTURE
//  - pulse_pkg: state enum {WARMUP,SEARCH,RISE,REFRACT}, DATA_W/CNT_W defaults.
//  - One sub-module: sat_counter (CNT_W, enable, clear, saturate at MAX), used for interval
//    and for the WARMUP/REFRACT counters. Rest flat in this module.
// TESTING (WARMUP=4, HYST=16, REFRACT=8, MAX_PERIOD=200, sample_en=1 unless stated)
//  1 Triangle 100..500, period 100 samples -> beat every 100 samples, ac_amp=400,
//    dc_level=100; 1st beat hr_valid=0 period=0; 2nd beat period=100, hr_valid=1.
//  2 Constant 300 after beats -> no beat; 200 samples after last beat pulse_lost=1 for one
//    cycle, hr_valid=0, period=0; triangle resumes -> hr_valid again only on 2nd beat.
//  3 Triangle plus +/-10 ripple at each sample -> exactly one beat per cycle (hysteresis and
//    REFRACT suppress double counts), period=100.
//  4 Test 1 with sample_en high every other clock -> period still 100; outputs hold on idle.
//  5 Out_Filtered steps 0 -> 2^20-1 -> 0 -> no overflow; beat with ac_amp=2^20-1.
//  6 rst_n low for one cycle mid-RISE -> all outputs 0 at once, no beat; WARMUP restarts.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared state encoding, default widths and a constant helper for the pulse peak detector.
package pulse_pkg;
  localparam int DATA_W_DEF = 20;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_WARMUP  = 2'd0,
    S_SEARCH  = 2'd1,
    S_RISE    = 2'd2,
    S_REFRACT = 2'd3
  } pulse_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; synchronous clear has priority over counting.
module sat_counter #(
  parameter int CNT_W = 16,
  parameter int MAX   = 4095
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != MAX_C)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/pulse_peak_detector.sv
// PPG pulse peak detector: hysteresis peak search, refractory blanking, beat period,
// per-beat AC amplitude / DC trough and pulse-loss timeout.
module pulse_peak_detector
  import pulse_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WARMUP     = 24,
  parameter int HYST       = 64,
  parameter int REFRACT    = 64,
  parameter int MAX_PERIOD = 4095
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] Out_Filtered,
  output logic              beat,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] ac_amp,
  output logic [DATA_W-1:0] dc_level,
  output logic              hr_valid,
  output logic              pulse_lost,
  output pulse_state_t      state_dbg_o
);
  localparam int                PHASE_MAX = max_int(WARMUP, REFRACT);
  localparam logic [DATA_W:0]   HYST_W    = (DATA_W + 1)'(HYST);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]  WARMUP_C  = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0]  REFRACT_C = CNT_W'(REFRACT);

  pulse_state_t      state_q;
  logic [DATA_W-1:0] thr_q, win_min_q, peak_q;
  logic              have_beat_q;

  logic [CNT_W-1:0]  interval_cnt, phase_cnt;
  logic [DATA_W-1:0] x_min, span;
  logic              rise_start, beat_hit, timeout, warm_done, refract_done;
  logic              phase_en, phase_clr, interval_clr;

  // Sums are formed one bit wider so thr+HYST and x+HYST cannot wrap near full scale.
  assign x_min        = (Out_Filtered < win_min_q) ? Out_Filtered : win_min_q;
  assign span         = peak_q - win_min_q;
  assign rise_start   = (state_q == S_SEARCH) && ({1'b0, Out_Filtered} > ({1'b0, thr_q} + HYST_W));
  assign beat_hit     = (state_q == S_RISE) && (({1'b0, Out_Filtered} + HYST_W) < {1'b0, peak_q});
  assign timeout      = ((state_q == S_SEARCH) || (state_q == S_RISE)) && !beat_hit &&
                        (interval_cnt >= (MAX_C - 1'b1));
  assign warm_done    = (state_q == S_WARMUP) && (phase_cnt == (WARMUP_C - 1'b1));
  assign refract_done = (state_q == S_REFRACT) && (phase_cnt == (REFRACT_C - 1'b1));

  assign phase_en     = sample_en && ((state_q == S_WARMUP) || (state_q == S_REFRACT));
  assign phase_clr    = sample_en && (warm_done || refract_done || beat_hit || timeout);
  assign interval_clr = sample_en && (warm_done || beat_hit || timeout);

  sat_counter #(.CNT_W(CNT_W), .MAX(MAX_PERIOD)) u_interval (
    .clk_i   (CLK_Filter),
    .rst_ni  (rst_n),
    .en_i    (sample_en),
    .clr_i   (interval_clr),
    .count_o (interval_cnt)
  );

  sat_counter #(.CNT_W(CNT_W), .MAX(PHASE_MAX)) u_phase (
    .clk_i   (CLK_Filter),
    .rst_ni  (rst_n),
    .en_i    (phase_en),
    .clr_i   (phase_clr),
    .count_o (phase_cnt)
  );

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WARMUP;
      thr_q       <= '0;
      win_min_q   <= '0;
      peak_q      <= '0;
      have_beat_q <= 1'b0;
      beat        <= 1'b0;
      pulse_lost  <= 1'b0;
      period      <= '0;
      ac_amp      <= '0;
      dc_level    <= '0;
      hr_valid    <= 1'b0;
    end else begin
      beat       <= 1'b0;
      pulse_lost <= 1'b0;
      if (sample_en) begin
        if (beat_hit) begin
          beat      <= 1'b1;
          ac_amp    <= span;
          dc_level  <= win_min_q;
          thr_q     <= win_min_q + (span >> 1);
          win_min_q <= Out_Filtered;
          state_q   <= S_REFRACT;
          if (have_beat_q) begin
            period   <= interval_cnt + 1'b1;
            hr_valid <= 1'b1;
          end
          have_beat_q <= 1'b1;
        end else if (timeout) begin
          pulse_lost  <= 1'b1;
          hr_valid    <= 1'b0;
          have_beat_q <= 1'b0;
          period      <= '0;
          state_q     <= S_WARMUP;
        end else begin
          unique case (state_q)
            S_WARMUP: begin
              if (warm_done) begin
                win_min_q <= Out_Filtered;
                thr_q     <= Out_Filtered;
                state_q   <= S_SEARCH;
              end
            end
            S_SEARCH: begin
              win_min_q <= x_min;
              if (rise_start) begin
                peak_q  <= Out_Filtered;
                state_q <= S_RISE;
              end
            end
            S_RISE: begin
              if (Out_Filtered > peak_q) peak_q <= Out_Filtered;
            end
            S_REFRACT: begin
              win_min_q <= x_min;
              if (refract_done) state_q <= S_SEARCH;
            end
          endcase
        end
      end
    end
  end

  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_pulse_peak_detector.sv
// Self-checking bench for pulse_peak_detector against a sample-level reference model.
module tb_pulse_peak_detector;
  import pulse_pkg::*;

  localparam int DATA_W = 20, CNT_W = 16, WARMUP = 4, HYST = 16, REFRACT = 8, MAX_PERIOD = 200;
  localparam int OUT_W  = 3 + CNT_W + 2 * DATA_W;
  localparam int FULL   = (1 << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_en = 1'b0;
  logic [DATA_W-1:0] x_in = '0;
  logic              beat, hr_valid, pulse_lost;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] ac_amp, dc_level;
  pulse_state_t      state_dbg;

  always #5 clk = ~clk;

  pulse_peak_detector #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .WARMUP(WARMUP), .HYST(HYST),
    .REFRACT(REFRACT), .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .CLK_Filter   (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .Out_Filtered (x_in),
    .beat         (beat),
    .period       (period),
    .ac_amp       (ac_amp),
    .dc_level     (dc_level),
    .hr_valid     (hr_valid),
    .pulse_lost   (pulse_lost),
    .state_dbg_o  (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];

  // Reference model: countdowns for warm-up and blanking, a tracking flag, samples since beat.
  int m_warm, m_blank, m_since, m_lo, m_thr, m_pk;
  bit m_track, m_have;
  logic m_beat, m_lost, m_hr;
  logic [CNT_W-1:0]  m_period;
  logic [DATA_W-1:0] m_ac, m_dc;

  task automatic model_reset();
    m_warm = WARMUP; m_blank = 0; m_since = 0; m_lo = 0; m_thr = 0; m_pk = 0;
    m_track = 0; m_have = 0;
    m_beat = 0; m_lost = 0; m_hr = 0; m_period = '0; m_ac = '0; m_dc = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input int x);
    bit fire;
    bit live;
    fire = 0; live = 0;
    m_beat = 0; m_lost = 0;
    m_since++;
    if (m_warm > 0) begin
      m_warm--;
      if (m_warm == 0) begin m_lo = x; m_thr = x; m_since = 0; end
    end else if (m_blank > 0) begin
      m_blank--;
      if (x < m_lo) m_lo = x;
    end else begin
      live = 1;
      if (!m_track) begin
        if (x < m_lo) m_lo = x;
        if (x > m_thr + HYST) begin m_pk = x; m_track = 1; end
      end else if (x + HYST < m_pk) fire = 1;
      else if (x > m_pk) m_pk = x;
    end
    if (fire) begin
      m_beat = 1;
      m_ac = DATA_W'(m_pk - m_lo);
      m_dc = DATA_W'(m_lo);
      m_thr = m_lo + (m_pk - m_lo) / 2;
      if (m_have) begin m_period = CNT_W'(m_since); m_hr = 1; end
      m_have = 1; m_lo = x; m_since = 0; m_track = 0; m_blank = REFRACT;
    end else if (live && m_since >= MAX_PERIOD) begin
      m_lost = 1; m_hr = 0; m_period = '0; m_have = 0; m_track = 0;
      m_warm = WARMUP; m_since = 0;
    end
  endtask

  function automatic logic [OUT_W-1:0] model_vec();
    return {m_beat, m_lost, m_hr, m_period, m_ac, m_dc};
  endfunction

  function automatic logic [OUT_W-1:0] dut_vec();
    return {beat, pulse_lost, hr_valid, period, ac_amp, dc_level};
  endfunction

  function automatic int tri_base(input int p);
    int q;
    q = p % 100;
    return (q <= 90) ? 100 + (400 * q) / 90 : 500 - 40 * (q - 90);
  endfunction

  task automatic drive(input int x, input bit en);
    x_in = DATA_W'(x);
    sample_en = en;
    if (en) model_step(x);
    else begin m_beat = 0; m_lost = 0; end
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", dut_vec());
    end
    checks++;
    if (state_dbg !== S_WARMUP) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_WARMUP);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_triangle();
    logic [OUT_W-1:0] got, exp;
    int nb;
    nb = 0;
    for (int i = 0; i < 500; i++) begin
      drive(tri_base(i), 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL triangle i=%0d: got %h expected %h", i, got, exp); end
      if (beat) begin
        nb++; checks++;
        if (nb == 1 && {hr_valid, period} !== '0) begin
          errors++; $display("FAIL triangle_first_beat: hr=%0d period=%0d expected 0/0", hr_valid, period);
        end else if (nb > 1 && {hr_valid, period, ac_amp, dc_level} !== {1'b1, 16'd100, 20'd400, 20'd100}) begin
          errors++;
          $display("FAIL triangle_beat: hr=%0d period=%0d ac=%0d dc=%0d expected 1/100/400/100",
                   hr_valid, period, ac_amp, dc_level);
        end
      end
    end
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL triangle_beat_count: got %0d expected 5", nb); end
  endtask

  task automatic test_timeout();
    logic [OUT_W-1:0] got, exp;
    int nl, nb;
    nl = 0; nb = 0;
    for (int i = 0; i < 250; i++) begin
      drive(300, 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout_flat i=%0d: got %h expected %h", i, got, exp); end
      if (pulse_lost) nl++;
      if (beat) nb++;
    end
    checks++;
    if (nl !== 1 || nb !== 0) begin
      errors++; $display("FAIL timeout_count: lost=%0d beats=%0d expected 1/0", nl, nb);
    end
    checks++;
    if ({hr_valid, period} !== '0) begin
      errors++; $display("FAIL timeout_clear: hr=%0d period=%0d expected 0/0", hr_valid, period);
    end
    for (int i = 0; i < 300; i++) begin
      drive(tri_base(i), 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout_resume i=%0d: got %h expected %h", i, got, exp); end
      if (beat) begin
        nb++; checks++;
        if (hr_valid !== (nb > 1)) begin
          errors++; $display("FAIL timeout_hr_valid beat=%0d: got %0d expected %0d", nb, hr_valid, nb > 1);
        end
      end
    end
    checks++;
    if (nb !== 3) begin errors++; $display("FAIL timeout_resume_beats: got %0d expected 3", nb); end
  endtask

  task automatic test_ripple();
    logic [OUT_W-1:0] got, exp;
    int nb, x;
    nb = 0;
    for (int i = 0; i < 400; i++) begin
      x = tri_base(i) + int'($urandom_range(0, 20)) - 10;
      drive(x, 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL ripple i=%0d: got %h expected %h", i, got, exp); end
      if (beat) begin
        nb++; checks++;
        if (period !== 16'd100) begin errors++; $display("FAIL ripple_period: got %0d expected 100", period); end
      end
    end
    checks++;
    if (nb !== 4) begin errors++; $display("FAIL ripple_beat_count: got %0d expected 4", nb); end
  endtask

  task automatic test_sparse_enable();
    logic [OUT_W-1:0] got, exp;
    int nb;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      drive(tri_base(i), 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sparse_active i=%0d: got %h expected %h", i, got, exp); end
      if (beat) begin
        nb++; checks++;
        if (period !== 16'd100) begin errors++; $display("FAIL sparse_period: got %0d expected 100", period); end
      end
      drive(int'($urandom_range(0, FULL)), 1'b0);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sparse_idle i=%0d: got %h expected %h", i, got, exp); end
    end
    checks++;
    if (nb !== 3) begin errors++; $display("FAIL sparse_beat_count: got %0d expected 3", nb); end
  endtask

  task automatic test_reset_mid_rise();
    logic [OUT_W-1:0] got, exp;
    int nb;
    nb = 0;
    for (int i = 0; i < 160; i++) begin
      drive(tri_base(i), 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_rise_pre i=%0d: got %h expected %h", i, got, exp); end
    end
    checks++;
    if (state_dbg !== S_RISE) begin errors++; $display("FAIL mid_rise_state: got %0d expected %0d", state_dbg, S_RISE); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== '0 || state_dbg !== S_WARMUP) begin
      errors++; $display("FAIL mid_rise_async: got %h state %0d expected 0 state 0", dut_vec(), state_dbg);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== '0) begin errors++; $display("FAIL mid_rise_held: got %h expected 0", dut_vec()); end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      drive(tri_base(i), 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_rise_post i=%0d: got %h expected %h", i, got, exp); end
      if (beat) nb++;
    end
    checks++;
    if (nb !== 2) begin errors++; $display("FAIL mid_rise_beats: got %0d expected 2", nb); end
  endtask

  task automatic test_full_scale_step();
    logic [OUT_W-1:0] got, exp;
    int nb, x;
    nb = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 28; i++) begin
      x = (i == 6 || i == 7) ? FULL : 0;
      drive(x, 1'b1);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL step i=%0d: got %h expected %h", i, got, exp); end
      if (beat) begin
        nb++; checks++;
        if (ac_amp !== 20'hFFFFF || dc_level !== '0) begin
          errors++; $display("FAIL step_amp: ac=%0h dc=%0h expected fffff/0", ac_amp, dc_level);
        end
      end
    end
    checks++;
    if (nb !== 1) begin errors++; $display("FAIL step_beat_count: got %0d expected 1", nb); end
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] got, exp;
    int v, r;
    bit en;
    v = 300;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 15));
      if (r == 0) v = int'($urandom_range(0, FULL));
      else if (r < 4) v = v + int'($urandom_range(0, 40)) - 20;
      if (v < 0) v = 0;
      if (v > FULL) v = FULL;
      drive(v, en);
      got = dut_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL random i=%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_triangle();
    test_timeout();
    test_ripple();
    test_sparse_enable();
    test_reset_mid_rise();
    test_full_scale_step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
